// File: rtl/gradient_accum_sink_if.sv
// rtl/gradient_accum_sink_if.sv - write stream bundle between the compressor and the accumulator sink
interface gradient_accum_sink_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int VAL_WIDTH  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [VAL_WIDTH-1:0]  in_value;

    modport master (output in_valid, output in_addr, output in_value, input in_ready);
    modport slave  (input in_valid, input in_addr, input in_value, output in_ready);
endinterface

// File: rtl/gradient_accum_sink.sv
// rtl/gradient_accum_sink.sv - pipelined saturating read-modify-write accumulator memory with readback
module gradient_accum_sink #(
    parameter int                     ADDR_WIDTH = 32,
    parameter int                     VAL_WIDTH  = 32,
    parameter int                     MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 'h1000,
    parameter int                     CNT_WIDTH  = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    gradient_accum_sink_if.slave         wr,
    input  logic                         clear,
    input  logic                         rd_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] rd_index,
    output logic                         rd_valid,
    output logic [VAL_WIDTH-1:0]         rd_data,
    output logic [CNT_WIDTH-1:0]         write_count,
    output logic [CNT_WIDTH-1:0]         sat_count,
    output logic [CNT_WIDTH-1:0]         oob_count,
    output logic                         idle
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state_q, state_d;
    logic                 clr_pend_q, clr_pend_d;
    logic [IDX_W-1:0]     clr_idx;
    logic                 go_clear;

    logic                 s1_valid;
    logic [IDX_W-1:0]     s1_idx;
    logic [VAL_WIDTH-1:0] s1_val;
    logic                 s2_valid;
    logic [IDX_W-1:0]     s2_idx;
    logic [VAL_WIDTH-1:0] s2_sum;

    logic [VAL_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word;
    logic                  in_range;
    logic [VAL_WIDTH-1:0]  operand;
    logic [VAL_WIDTH:0]    sum_ext;
    logic                  overflow;
    logic [VAL_WIDTH-1:0]  sum_clamped;

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign wr.in_ready = (state_q == RUN) && !clr_pend_q;
    assign accept      = wr.in_valid && wr.in_ready;
    assign idle        = (state_q == RUN) && !s1_valid && !s2_valid && !wr.in_valid;

    assign offset   = wr.in_addr - BASE_ADDR;
    assign word     = offset >> 2;
    assign in_range = (wr.in_addr >= BASE_ADDR) && (word[ADDR_WIDTH-1:IDX_W] == '0)
                      && (wr.in_addr[1:0] == 2'b00);

    // The entry being written this edge by S2 is newer than what the array still holds.
    assign operand  = (s2_valid && (s2_idx == s1_idx)) ? s2_sum : mem[s1_idx];
    assign sum_ext  = {operand[VAL_WIDTH-1], operand} + {s1_val[VAL_WIDTH-1], s1_val};
    assign overflow = sum_ext[VAL_WIDTH] != sum_ext[VAL_WIDTH-1];
    assign sum_clamped = !overflow ? sum_ext[VAL_WIDTH-1:0]
                       : sum_ext[VAL_WIDTH] ? {1'b1, {(VAL_WIDTH-1){1'b0}}}
                                            : {1'b0, {(VAL_WIDTH-1){1'b1}}};

    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        go_clear   = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_idx == IDX_W'(MEM_DEPTH - 1)) state_d = RUN;
            end
            RUN: begin
                if (clear) clr_pend_d = 1'b1;
                if (clr_pend_q && !s1_valid && !s2_valid) begin
                    go_clear   = 1'b1;
                    state_d    = CLEAR;
                    clr_pend_d = 1'b0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clr_pend_q  <= 1'b0;
            clr_idx     <= '0;
            s1_valid    <= 1'b0;
            s1_idx      <= '0;
            s1_val      <= '0;
            s2_valid    <= 1'b0;
            s2_idx      <= '0;
            s2_sum      <= '0;
            write_count <= '0;
            sat_count   <= '0;
            oob_count   <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            if (state_q == CLEAR) clr_idx <= clr_idx + 1'b1;

            s1_valid <= accept && in_range;
            s1_idx   <= word[IDX_W-1:0];
            s1_val   <= wr.in_value;
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            s2_sum   <= sum_clamped;

            if (go_clear) begin
                write_count <= '0;
                sat_count   <= '0;
                oob_count   <= '0;
            end else begin
                if (accept && in_range)  write_count <= cnt_inc(write_count);
                if (accept && !in_range) oob_count   <= cnt_inc(oob_count);
                if (s1_valid && overflow) sat_count  <= cnt_inc(sat_count);
            end

            // Write-first: a read sees whatever lands in the array on this same edge.
            rd_valid <= rd_en;
            if (rd_en) begin
                if (state_q == CLEAR && clr_idx == rd_index)
                    rd_data <= '0;
                else if (s2_valid && s2_idx == rd_index)
                    rd_data <= s2_sum;
                else
                    rd_data <= mem[rd_index];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == CLEAR)
            mem[clr_idx] <= '0;
        else if (s2_valid)
            mem[s2_idx] <= s2_sum;
    end
endmodule

// File: tb/tb_gradient_accum_sink.sv
// tb/tb_gradient_accum_sink.sv - directed bench with a sequential accumulation model for gradient_accum_sink
module tb_gradient_accum_sink;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_index = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [15:0] write_count, sat_count, oob_count;
    logic        idle;

    always #5 clock = ~clock;

    gradient_accum_sink_if #(.ADDR_WIDTH(32), .VAL_WIDTH(32)) wr_if ();

    gradient_accum_sink #(
        .ADDR_WIDTH(32), .VAL_WIDTH(32), .MEM_DEPTH(256), .BASE_ADDR(32'h1000), .CNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .wr(wr_if), .clear(clear),
        .rd_en(rd_en), .rd_index(rd_index), .rd_valid(rd_valid), .rd_data(rd_data),
        .write_count(write_count), .sat_count(sat_count), .oob_count(oob_count), .idle(idle)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: every accepted write is applied immediately and in order.
    int  mm [256];
    int  wc, oc, sc, sc_pend;
    int  sweep_left;
    bit  pend;
    int  trans_at, last_hs, cyc;
    int  rdq [$];
    bit  exp_rdv;

    task automatic model_write(input logic [31:0] addr, input logic [31:0] val);
        longint a, s;
        int i;
        a = longint'(addr);
        if (a < 4096 || (a - 4096) / 4 >= 256 || a % 4 != 0) begin
            oc++;
        end else begin
            i = int'((a - 4096) / 4);
            s = longint'(mm[i]) + longint'($signed(val));
            if (s > 64'sd2147483647) begin
                s = 64'sd2147483647; sc_pend++;
            end else if (s < -64'sd2147483648) begin
                s = -64'sd2147483648; sc_pend++;
            end
            mm[i] = int'(s);
            wc++;
            last_hs = cyc;
        end
    endtask

    always @(posedge clock) begin
        if (!reset_n) begin
            foreach (mm[k]) mm[k] = 0;
            wc = 0; oc = 0; sc = 0; sc_pend = 0;
            sweep_left = 256; pend = 0; trans_at = 0; last_hs = -100; cyc = 0;
            exp_rdv = 0; rdq.delete();
        end else begin
            cyc++;
            sc += sc_pend; sc_pend = 0;
            exp_rdv = rd_en;
            if (rd_en) rdq.push_back(mm[rd_index]);
            if (wr_if.in_valid && sweep_left == 0 && !pend)
                model_write(wr_if.in_addr, wr_if.in_value);
            if (sweep_left > 0) begin
                sweep_left--;
            end else if (pend) begin
                if (cyc == trans_at) begin
                    foreach (mm[k]) mm[k] = 0;
                    wc = 0; oc = 0; sc = 0;
                    sweep_left = 256; pend = 0;
                end
            end else if (clear) begin
                pend = 1;
                trans_at = (last_hs + 3 > cyc + 1) ? last_hs + 3 : cyc + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("in_ready", longint'(wr_if.in_ready), longint'(sweep_left == 0 && !pend));
            chk("write_count", longint'(write_count), longint'(wc));
            chk("oob_count", longint'(oob_count), longint'(oc));
            chk("sat_count", longint'(sat_count), longint'(sc));
            chk("idle", longint'(idle),
                longint'(sweep_left == 0 && last_hs < cyc - 1 && !wr_if.in_valid));
            chk("rd_valid", longint'(rd_valid), longint'(exp_rdv));
            if (rd_valid && exp_rdv && rdq.size() > 0)
                chk("rd_data", longint'($signed(rd_data)), longint'(rdq.pop_front()));
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        wr_if.in_valid = 1'b1; wr_if.in_addr = a; wr_if.in_value = v;
        @(posedge clock); #2;
    endtask

    task automatic nop(input int n);
        wr_if.in_valid = 1'b0;
        repeat (n) begin @(posedge clock); #2; end
    endtask

    task automatic rd(input int idx, output int val);
        rd_en = 1'b1; rd_index = 8'(idx);
        @(posedge clock); #2;
        rd_en = 1'b0;
        val = $signed(rd_data);
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (!wr_if.in_ready && n < budget) begin @(posedge clock); #2; n++; end
        if (!wr_if.in_ready) chk("ready_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v, n;
        wr_if.in_valid = 1'b0; wr_if.in_addr = '0; wr_if.in_value = '0;
        #3;
        chk("rst_in_ready", longint'(wr_if.in_ready), 0);
        chk("rst_rd_valid", longint'(rd_valid), 0);
        chk("rst_rd_data", longint'(rd_data), 0);
        chk("rst_counts", longint'(write_count) + oob_count + sat_count, 0);
        chk("rst_idle", longint'(idle), 0);
        repeat (2) @(posedge clock); #2 reset_n = 1'b1;

        // Reset mid-sweep, then a clear pulse during the restarted sweep.
        repeat (50) begin @(posedge clock); #2; end
        reset_n = 1'b0;
        repeat (2) @(posedge clock); #2 reset_n = 1'b1;
        n = 0;
        while (!wr_if.in_ready && n < 400) begin
            @(posedge clock); #1; n++;
            clear = (n == 100);
        end
        #1 clear = 1'b0;
        chk("t1_ready_latency", n, 256);
        for (int i = 0; i < 256; i++) begin
            rd(i, v);
            if (v != 0) chk("t1_zero_entry", v, 0);
        end
        chk("t1_last_entry", v, 0);

        for (int i = 0; i < 8; i++) wr(32'h1000, (i == 0) ? 32'd30 : 32'd10);
        nop(3);
        rd(0, v);
        chk("t2_mem0", v, 100);
        chk("t2_model_mem0", mm[0], 100);
        chk("t2_write_count", longint'(write_count), 8);

        wr(32'h1004, 32'd150); wr(32'h1008, -32'sd200);
        nop(3);
        rd(1, v); chk("t3_mem1", v, 150);
        rd(2, v); chk("t3_mem2", v, -200);

        wr(32'h100C, 32'h7FFFFFF0); wr(32'h100C, 32'h20);
        nop(3);
        rd(3, v); chk("t4_pos_sat", v, 32'sh7FFFFFFF);
        chk("t4_sat_count", longint'(sat_count), 1);
        wr(32'h1010, 32'h80000010); wr(32'h1010, 32'hFFFFFFE0);
        nop(3);
        rd(4, v); chk("t4_neg_sat", v, -64'sd2147483648);
        chk("t4_sat_count2", longint'(sat_count), 2);

        wr(32'h1014, 1); wr(32'h1018, 2); wr(32'h1014, 3); wr(32'h1014, 4); wr(32'h1018, 5);
        nop(3);
        rd(5, v); chk("hz_mem5", v, 8);
        rd(6, v); chk("hz_mem6", v, 7);

        wr(32'h0FFC, 1); wr(32'h1400, 1); wr(32'h1002, 1);
        nop(3);
        chk("t5_oob_count", longint'(oob_count), 3);
        chk("t5_write_count", longint'(write_count), 19);
        rd(0, v); chk("t5_mem0_kept", v, 100);

        wr(32'h1020, 5);
        clear = 1'b1;
        wr(32'h1024, 7);
        clear = 1'b0; wr_if.in_valid = 1'b0;
        chk("t6_inflight_count", longint'(write_count), 21);
        rd(8, v); chk("t6_commit8", v, 5);
        rd(9, v); chk("t6_commit9", v, 7);
        wait_ready(400, n);
        chk("t6_sweep_len", n, 257);
        chk("t6_counts_zero", longint'(write_count) + oob_count + sat_count, 0);
        rd(8, v); chk("t6_mem8", v, 0);
        rd(0, v); chk("t6_mem0", v, 0);
        rd(3, v); chk("t6_mem3", v, 0);
        nop(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
